p2a_cpl_ingress_buffer: RTL and testbench
=========================================

// Module: p2a_cpl_ingress_buffer
// PURPOSE
//  Parametrised completion buffer between Rx Router and P2A Push FSM (successor of direct Rx Router->P2A path).
//  Stores completion beats in a DEPTH-entry FWFT FIFO and replays them to the Push FSM as one header phase
//  (Cpl_Command=0) plus N data phases (Cpl_Command=1), N derived from the header length and DATA_WIDTH.
// PARAMETERS
//  DATA_WIDTH  1024  payload bits per beat; power of two, 32..4096
//  DEPTH       16    FIFO entries (beats); power of two, >=2
//  CNT_W       32    width of statistics counters (only with P2A_CPL_STATS_EN)
// PORTS
//  ACLK           in   1               clock
//  ARESET         in   1               asynchronous reset, active-high
//  Resp_HDR       in   Cpl_TLP_HDR_t   completion header; valid and identical on every beat of a completion
//  Resp_Data      in   DATA_WIDTH      payload beat
//  Resp_Valid     in   1               Rx Router beat valid
//  Resp_Grant     out  1               buffer accepts beat (= !full)
//  Cpl_Valid      out  1               head entry available to Push FSM
//  Cpl_Type       out  cpl_t           CPL (no data) / CPLD, decoded from head header Fmt
//  Cpl_Length     out  10              head header Length field (DW, 0 = 1024)
//  Cpl_Data       out  DATA_WIDTH      head entry payload
//  Cpl_Grant      in   1               Push FSM consumes current phase
//  Cpl_Command    in   1               0 = header phase, 1 = data phase
//  Cpl_Seq_Err    out  1               sticky: Cpl_Grant with Cpl_Command not matching phase
//  Cpl_Count      out  CNT_W           [P2A_CPL_STATS_EN] completions fully delivered
//  Cpl_Stat_Err   out  CNT_W           [P2A_CPL_STATS_EN] delivered completions with status != SC
// BEHAVIOUR
//  Reset: FIFO empty, phase = HDR_PH, Resp_Grant=1, Cpl_Valid=0, Cpl_Seq_Err=0, counters=0; Cpl_Type/Length/Data
//   show entry 0 (don't-care while Cpl_Valid=0). Reset mid-completion discards all stored beats.
//  Write: Resp_Valid & Resp_Grant stores {HDR,Data} at wr_ptr, wr_ptr++ (mod DEPTH). Resp_Grant = !full from
//   registered occupancy; no write at full even with a same-cycle pop (pop frees slot next cycle).
//  Latency: beat written at edge N -> Cpl_Valid=1 after edge N (visible cycle N+1). Outputs combinational from head.
//  Beats per CPLD: B = ceil(L*32/DATA_WIDTH), L = Length (0 -> 1024); B >= 1. CPL (no data) occupies 1 entry.
//  Phase FSM (2 states), acts only when Cpl_Valid=1 & Cpl_Grant=1:
//   HDR_PH, Cmd=0: CPL -> pop, stay HDR_PH; CPLD -> load rem=B, go DATA_PH, no pop.
//   DATA_PH, Cmd=1: pop; rem==1 -> HDR_PH, else rem--.
//   Cmd mismatch: no pop, no state change, Cpl_Seq_Err<=1 (cleared only by reset).
//  Cpl_Grant while Cpl_Valid=0: ignored, no error. Empty in DATA_PH (Rx mid-completion): wait, hold rem.
//  Simultaneous write and pop: both occur; occupancy unchanged. Pointers wrap modulo DEPTH.
//  Occupancy counter width $clog2(DEPTH)+1; full = occ==DEPTH, empty = occ==0.
// CONFIGURATION
//  `P2A_CPL_STATS_EN defined: Cpl_Count increments on last-phase pop of each completion (CPL header pop or CPLD
//   final data pop); Cpl_Stat_Err increments at the same point if header Cpl_Status != SC. Both wrap at 2^CNT_W.
//  Not defined: Cpl_Count/Cpl_Stat_Err ports and counter logic absent; all other behaviour identical.
// STRUCTURE
//  axi_slave_package: cpl_t, Cpl_TLP_HDR_t, CPL_STATUS_SC, CPL_LEN_MAX_DW=1024, beat-count function cpl_beats().
//  Sub-module p2a_cpl_fifo_mem: storage array + pointers + occupancy, FWFT read; top holds phase FSM/counters.
// TESTING
//  1 DATA_WIDTH=1024, CPLD L=32 one beat -> Grant Cmd0 then Cmd1: pops once, Cpl_Count=1, phase back HDR_PH.
//  2 CPLD L=0 (1024 DW), DATA_WIDTH=1024 -> 32 beats; 32 Cmd1 grants required, 33rd Cmd1 grant sets Cpl_Seq_Err.
//  3 Fill DEPTH=16 beats with no grants -> Resp_Grant=0 on cycle after 16th write; 17th beat held until a pop.
//  4 CPL no-data status UR, Grant Cmd0 -> popped, Cpl_Stat_Err=1, no DATA_PH entered.
//  5 Write and pop same cycle at occupancy 8 -> occupancy stays 8; pointer wrap over 3xDEPTH beats, data order intact.
//  6 ARESET asserted in DATA_PH with rem=5 -> Cpl_Valid=0, phase HDR_PH, Resp_Grant=1 immediately.

Source files
------------

// File: rtl/p2a_cpl_ingress_buffer_pkg.sv
// Shared completion types for the P2A completion ingress buffer:
// completion header layout, completion kind, phase encoding and the
// beats-per-completion helper.
package axi_slave_package;

    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
    localparam logic [2:0] CPL_STATUS_CA  = 3'b100;
    localparam int         CPL_LEN_MAX_DW = 1024;

    typedef enum logic {
        CPL  = 1'b0,
        CPLD = 1'b1
    } cpl_t;

    typedef enum logic {
        HDR_PH  = 1'b0,
        DATA_PH = 1'b1
    } phase_t;

    // 3DW completion header, DW0 first (MSBs)
    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  tlp_type;
        logic [13:0] misc;
        logic [9:0]  length;
        logic [15:0] completer_id;
        logic [2:0]  cpl_status;
        logic        bcm;
        logic [11:0] byte_count;
        logic [15:0] requester_id;
        logic [7:0]  tag;
        logic        rsvd;
        logic [6:0]  lower_addr;
    } Cpl_TLP_HDR_t;

    // Number of payload beats for a CPLD of len DW on a dw-bit bus (len 0 = 1024 DW)
    function automatic logic [10:0] cpl_beats(input logic [9:0] len, input int dw);
        int l_dw;
        int dw_per_beat;
        l_dw        = (len == 10'd0) ? CPL_LEN_MAX_DW : int'(len);
        dw_per_beat = dw / 32;
        return 11'((l_dw + dw_per_beat - 1) / dw_per_beat);
    endfunction

endpackage

// File: rtl/p2a_cpl_ingress_buffer_fifo_mem.sv
// First-word-fall-through storage for completion beats: array, read/write
// pointers and occupancy counter. The head entry is presented combinationally.
module p2a_cpl_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [OW-1:0] occ_reg;
    logic          do_wr;
    logic          do_rd;

    assign full    = (occ_reg == OW'(DEPTH));
    assign empty   = (occ_reg == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage array; contents are not reset, only the pointers are
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/p2a_cpl_ingress_buffer.sv
// Completion ingress buffer between the Rx Router and the P2A Push FSM.
// Beats are queued in a FWFT FIFO and replayed as one header phase followed
// by the completion's data phases. Optional statistics counters are built
// when P2A_CPL_STATS_EN is defined.
module p2a_cpl_ingress_buffer
    import axi_slave_package::*;
#(
    parameter int DATA_WIDTH = 1024,
    parameter int DEPTH      = 16
`ifdef P2A_CPL_STATS_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  Cpl_TLP_HDR_t          Resp_HDR,
    input  logic [DATA_WIDTH-1:0] Resp_Data,
    input  logic                  Resp_Valid,
    output logic                  Resp_Grant,
    output logic                  Cpl_Valid,
    output cpl_t                  Cpl_Type,
    output logic [9:0]            Cpl_Length,
    output logic [DATA_WIDTH-1:0] Cpl_Data,
    input  logic                  Cpl_Grant,
    input  logic                  Cpl_Command,
    output logic                  Cpl_Seq_Err
`ifdef P2A_CPL_STATS_EN
    ,
    output logic [CNT_W-1:0]      Cpl_Count,
    output logic [CNT_W-1:0]      Cpl_Stat_Err
`endif
);
    localparam int HDR_W = $bits(Cpl_TLP_HDR_t);
    localparam int ENT_W = HDR_W + DATA_WIDTH;

    logic [ENT_W-1:0] head;
    Cpl_TLP_HDR_t     head_hdr;
    logic             full;
    logic             empty;
    logic             pop;
    logic             last_pop;
    phase_t           phase_reg, phase_next;
    logic [10:0]      rem_reg, rem_next;
    logic             seq_err_reg, seq_err_next;
    logic             unused_hdr;

    p2a_cpl_fifo_mem #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (Resp_Valid),
        .wr_data ({Resp_HDR, Resp_Data}),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    assign head_hdr    = head[ENT_W-1 -: HDR_W];
    assign Resp_Grant  = !full;
    assign Cpl_Valid   = !empty;
    assign Cpl_Type    = head_hdr.fmt[1] ? CPLD : CPL;
    assign Cpl_Length  = head_hdr.length;
    assign Cpl_Data    = head[DATA_WIDTH-1:0];
    assign Cpl_Seq_Err = seq_err_reg;
    assign unused_hdr  = ^head_hdr;

    // Phase state, remaining data beats and sticky sequence error
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            phase_reg   <= HDR_PH;
            rem_reg     <= '0;
            seq_err_reg <= 1'b0;
        end else begin
            phase_reg   <= phase_next;
            rem_reg     <= rem_next;
            seq_err_reg <= seq_err_next;
        end
    end

    // Header/data phase sequencing; a header grant on a CPLD only arms the data phase
    always_comb begin
        phase_next   = phase_reg;
        rem_next     = rem_reg;
        seq_err_next = seq_err_reg;
        pop          = 1'b0;
        last_pop     = 1'b0;
        if (Cpl_Valid && Cpl_Grant) begin
            case (phase_reg)
                HDR_PH: begin
                    if (!Cpl_Command) begin
                        if (Cpl_Type == CPL) begin
                            pop      = 1'b1;
                            last_pop = 1'b1;
                        end else begin
                            rem_next   = cpl_beats(head_hdr.length, DATA_WIDTH);
                            phase_next = DATA_PH;
                        end
                    end else begin
                        seq_err_next = 1'b1;
                    end
                end
                DATA_PH: begin
                    if (Cpl_Command) begin
                        pop = 1'b1;
                        if (rem_reg == 11'd1) begin
                            phase_next = HDR_PH;
                            last_pop   = 1'b1;
                        end else begin
                            rem_next = rem_reg - 11'd1;
                        end
                    end else begin
                        seq_err_next = 1'b1;
                    end
                end
                default: phase_next = HDR_PH;
            endcase
        end
    end

`ifdef P2A_CPL_STATS_EN
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] stat_err_reg;

    assign Cpl_Count    = count_reg;
    assign Cpl_Stat_Err = stat_err_reg;

    // Completion and error-status counters, stepped on each completion's final pop
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            count_reg    <= '0;
            stat_err_reg <= '0;
        end else if (last_pop) begin
            count_reg <= count_reg + 1'b1;
            if (head_hdr.cpl_status != CPL_STATUS_SC) begin
                stat_err_reg <= stat_err_reg + 1'b1;
            end
        end
    end
`else
    logic unused_last_pop;
    assign unused_last_pop = last_pop;
`endif

endmodule

// File: tb/tb_p2a_cpl_ingress_buffer.sv
// Directed bench for p2a_cpl_ingress_buffer: a table of completions replayed
// through header/data phases, plus sequences for full, wrap, long CPLD,
// sequence errors and mid-completion reset. Counter checks are built when
// P2A_CPL_STATS_EN is defined.
module tb_p2a_cpl_ingress_buffer;
    import axi_slave_package::*;

    localparam int DW    = 1024;
    localparam int DEPTH = 16;

    logic            ACLK = 1'b0;
    logic            ARESET = 1'b1;
    Cpl_TLP_HDR_t    Resp_HDR = '0;
    logic [DW-1:0]   Resp_Data = '0;
    logic            Resp_Valid = 1'b0;
    logic            Resp_Grant;
    logic            Cpl_Valid;
    cpl_t            Cpl_Type;
    logic [9:0]      Cpl_Length;
    logic [DW-1:0]   Cpl_Data;
    logic            Cpl_Grant = 1'b0;
    logic            Cpl_Command = 1'b0;
    logic            Cpl_Seq_Err;
`ifdef P2A_CPL_STATS_EN
    logic [31:0]     Cpl_Count;
    logic [31:0]     Cpl_Stat_Err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int exp_count = 0;
    int exp_stat_err = 0;

    always #5 ACLK = ~ACLK;

    p2a_cpl_ingress_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .Resp_HDR    (Resp_HDR),
        .Resp_Data   (Resp_Data),
        .Resp_Valid  (Resp_Valid),
        .Resp_Grant  (Resp_Grant),
        .Cpl_Valid   (Cpl_Valid),
        .Cpl_Type    (Cpl_Type),
        .Cpl_Length  (Cpl_Length),
        .Cpl_Data    (Cpl_Data),
        .Cpl_Grant   (Cpl_Grant),
        .Cpl_Command (Cpl_Command),
        .Cpl_Seq_Err (Cpl_Seq_Err)
`ifdef P2A_CPL_STATS_EN
        ,
        .Cpl_Count   (Cpl_Count),
        .Cpl_Stat_Err(Cpl_Stat_Err)
`endif
    );

    typedef struct {
        bit         cpld;
        logic [9:0] len;
        logic [2:0] st;
        int         beats;
    } vec_t;

    vec_t vecs [7];

    function automatic Cpl_TLP_HDR_t mk_hdr(input bit cpld, input logic [9:0] len, input logic [2:0] st);
        Cpl_TLP_HDR_t h;
        h            = '0;
        h.fmt        = cpld ? 3'b010 : 3'b000;
        h.tlp_type   = 5'b01010;
        h.length     = len;
        h.cpl_status = st;
        return h;
    endfunction

    function automatic logic [DW-1:0] mk_data(input int tag);
        logic [31:0] t;
        t = 32'(tag);
        return {32{t}};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input int tag);
        n_cmp++;
        if (Cpl_Data !== mk_data(tag)) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (low word)", nm, Cpl_Data[31:0], 32'(tag));
        end
    endtask

    // One beat into the buffer, waiting (bounded) for Resp_Grant
    task automatic push_beat(input Cpl_TLP_HDR_t hdr, input int tag);
        int w;
        Resp_HDR   = hdr;
        Resp_Data  = mk_data(tag);
        Resp_Valid = 1'b1;
        w = 0;
        while (!Resp_Grant && w < 100) begin
            tick();
            w++;
        end
        if (!Resp_Grant) chk("push_grant_timeout", 64'(Resp_Grant), 64'd1);
        tick();
        Resp_Valid = 1'b0;
    endtask

    task automatic grant(input logic cmd);
        Cpl_Grant   = 1'b1;
        Cpl_Command = cmd;
        tick();
        Cpl_Grant   = 1'b0;
    endtask

    initial begin
        int tag;
        int wr_n;
        int pop_n;
        int budget;
        bit will_wr;
        bit will_pop;

        vecs[0] = '{1'b1, 10'd32,  CPL_STATUS_SC, 1};
        vecs[1] = '{1'b0, 10'd0,   CPL_STATUS_UR, 1};
        vecs[2] = '{1'b1, 10'd1,   CPL_STATUS_SC, 1};
        vecs[3] = '{1'b1, 10'd33,  CPL_STATUS_CA, 2};
        vecs[4] = '{1'b1, 10'd100, CPL_STATUS_SC, 4};
        vecs[5] = '{1'b1, 10'd512, CPL_STATUS_SC, 16};
        vecs[6] = '{1'b0, 10'd0,   CPL_STATUS_SC, 1};

        // Reset state
        repeat (3) tick();
        chk("rst_resp_grant", 64'(Resp_Grant), 64'd1);
        chk("rst_cpl_valid", 64'(Cpl_Valid), 64'd0);
        chk("rst_seq_err", 64'(Cpl_Seq_Err), 64'd0);
        ARESET = 1'b0;
        tick();
        chk("rst_phase", 64'(dut.phase_reg), 64'(HDR_PH));
        $display("reset: grant=%0d valid=%0d", Resp_Grant, Cpl_Valid);

        // Table of completions: fill beats, header phase, then data phases
        tag = 100;
        for (int v = 0; v < 7; v++) begin
            for (int b = 0; b < vecs[v].beats; b++) push_beat(mk_hdr(vecs[v].cpld, vecs[v].len, vecs[v].st), tag + b);
            chk($sformatf("v%0d_valid", v), 64'(Cpl_Valid), 64'd1);
            chk($sformatf("v%0d_type", v), 64'(Cpl_Type), 64'(vecs[v].cpld ? CPLD : CPL));
            chk($sformatf("v%0d_len", v), 64'(Cpl_Length), 64'(vecs[v].len));
            chk_data($sformatf("v%0d_data0", v), tag);
            grant(1'b0);
            if (vecs[v].cpld) begin
                chk($sformatf("v%0d_phase_data", v), 64'(dut.phase_reg), 64'(DATA_PH));
                chk($sformatf("v%0d_rem", v), 64'(dut.rem_reg), 64'(vecs[v].beats));
                chk($sformatf("v%0d_hdr_nopop", v), 64'(dut.u_fifo.occ_reg), 64'(vecs[v].beats));
                for (int b = 0; b < vecs[v].beats; b++) begin
                    chk_data($sformatf("v%0d_data%0d", v, b), tag + b);
                    grant(1'b1);
                end
            end else begin
                chk($sformatf("v%0d_no_data_ph", v), 64'(dut.phase_reg), 64'(HDR_PH));
            end
            exp_count++;
            if (vecs[v].st != CPL_STATUS_SC) exp_stat_err++;
            chk($sformatf("v%0d_drained", v), 64'(Cpl_Valid), 64'd0);
            chk($sformatf("v%0d_phase_hdr", v), 64'(dut.phase_reg), 64'(HDR_PH));
            chk($sformatf("v%0d_seq_err", v), 64'(Cpl_Seq_Err), 64'd0);
`ifdef P2A_CPL_STATS_EN
            chk($sformatf("v%0d_count", v), 64'(Cpl_Count), 64'(exp_count));
            chk($sformatf("v%0d_stat_err", v), 64'(Cpl_Stat_Err), 64'(exp_stat_err));
`endif
            $display("vec %0d: cpld=%0d len=%0d st=%0d beats=%0d", v, vecs[v].cpld, vecs[v].len, vecs[v].st, vecs[v].beats);
            tag += 100;
        end

        // Fill to DEPTH, 17th beat held until a pop frees a slot
        for (int i = 0; i < DEPTH; i++) push_beat(mk_hdr(1'b0, 10'd0, CPL_STATUS_SC), 3000 + i);
        chk("full_grant_low", 64'(Resp_Grant), 64'd0);
        chk("full_occ", 64'(dut.u_fifo.occ_reg), 64'(DEPTH));
        Resp_Data  = mk_data(3000 + DEPTH);
        Resp_Valid = 1'b1;
        repeat (3) tick();
        chk("full_hold_grant", 64'(Resp_Grant), 64'd0);
        chk("full_hold_occ", 64'(dut.u_fifo.occ_reg), 64'(DEPTH));
        chk_data("full_head", 3000);
        Cpl_Grant   = 1'b1;
        Cpl_Command = 1'b0;
        tick();
        Cpl_Grant = 1'b0;
        chk("full_pop_nowrite_occ", 64'(dut.u_fifo.occ_reg), 64'(DEPTH - 1));
        chk("full_pop_grant", 64'(Resp_Grant), 64'd1);
        tick();
        Resp_Valid = 1'b0;
        chk("full_refill_occ", 64'(dut.u_fifo.occ_reg), 64'(DEPTH));
        for (int i = 1; i <= DEPTH; i++) begin
            chk_data($sformatf("full_drain%0d", i), 3000 + i);
            grant(1'b0);
        end
        chk("full_empty", 64'(Cpl_Valid), 64'd0);
        exp_count += DEPTH + 1;
        $display("full test: %0d beats through a %0d-entry buffer", DEPTH + 1, DEPTH);

        // Simultaneous write/pop at occupancy 8, 3*DEPTH beats to exercise wrap
        for (int i = 0; i < 8; i++) push_beat(mk_hdr(1'b0, 10'd0, CPL_STATUS_SC), 5000 + i);
        wr_n  = 8;
        pop_n = 0;
        for (int k = 0; k < 3 * DEPTH - 8; k++) begin
            Resp_HDR    = mk_hdr(1'b0, 10'd0, CPL_STATUS_SC);
            Resp_Data   = mk_data(5000 + wr_n);
            Resp_Valid  = 1'b1;
            Cpl_Grant   = 1'b1;
            Cpl_Command = 1'b0;
            chk_data($sformatf("wrap_data%0d", pop_n), 5000 + pop_n);
            tick();
            wr_n++;
            pop_n++;
            chk($sformatf("wrap_occ%0d", k), 64'(dut.u_fifo.occ_reg), 64'd8);
        end
        Resp_Valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_data($sformatf("wrap_data%0d", pop_n), 5000 + pop_n);
            tick();
            pop_n++;
        end
        Cpl_Grant = 1'b0;
        chk("wrap_empty", 64'(Cpl_Valid), 64'd0);
        exp_count += 3 * DEPTH;
        $display("wrap test: %0d beats in order", pop_n);

        // CPLD L=0 (1024 DW) = 32 beats, streamed through the buffer
        for (int i = 0; i < DEPTH; i++) push_beat(mk_hdr(1'b1, 10'd0, CPL_STATUS_SC), 1000 + i);
        grant(1'b0);
        chk("long_rem", 64'(dut.rem_reg), 64'd32);
        wr_n   = DEPTH;
        pop_n  = 0;
        budget = 0;
        while (pop_n < 32 && budget < 200) begin
            Resp_HDR    = mk_hdr(1'b1, 10'd0, CPL_STATUS_SC);
            Resp_Data   = mk_data(1000 + wr_n);
            Resp_Valid  = (wr_n < 32);
            Cpl_Grant   = 1'b1;
            Cpl_Command = 1'b1;
            will_wr  = Resp_Valid && Resp_Grant;
            will_pop = Cpl_Valid;
            if (will_pop) chk_data($sformatf("long_data%0d", pop_n), 1000 + pop_n);
            tick();
            if (will_wr) wr_n++;
            if (will_pop) pop_n++;
            budget++;
        end
        Resp_Valid = 1'b0;
        Cpl_Grant  = 1'b0;
        chk("long_pops", 64'(pop_n), 64'd32);
        chk("long_empty", 64'(Cpl_Valid), 64'd0);
        chk("long_phase_hdr", 64'(dut.phase_reg), 64'(HDR_PH));
        chk("long_no_err", 64'(Cpl_Seq_Err), 64'd0);
        exp_count++;
        grant(1'b1);
        chk("grant_while_empty_no_err", 64'(Cpl_Seq_Err), 64'd0);
        push_beat(mk_hdr(1'b0, 10'd0, CPL_STATUS_SC), 2000);
        grant(1'b1);
        chk("extra_cmd1_seq_err", 64'(Cpl_Seq_Err), 64'd1);
        chk("extra_cmd1_nopop", 64'(Cpl_Valid), 64'd1);
        grant(1'b0);
        chk("seq_err_sticky", 64'(Cpl_Seq_Err), 64'd1);
        chk("after_err_pop", 64'(Cpl_Valid), 64'd0);
        exp_count++;
`ifdef P2A_CPL_STATS_EN
        chk("total_count", 64'(Cpl_Count), 64'(exp_count));
        chk("total_stat_err", 64'(Cpl_Stat_Err), 64'(exp_stat_err));
`endif
        $display("long cpld: 32 data phases, seq_err=%0d", Cpl_Seq_Err);

        // Reset in DATA_PH with rem=5 (L=160)
        for (int i = 0; i < 5; i++) push_beat(mk_hdr(1'b1, 10'd160, CPL_STATUS_SC), 6000 + i);
        grant(1'b0);
        chk("mid_rem5", 64'(dut.rem_reg), 64'd5);
        chk("mid_phase_data", 64'(dut.phase_reg), 64'(DATA_PH));
        ARESET = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(Cpl_Valid), 64'd0);
        chk("mid_rst_phase", 64'(dut.phase_reg), 64'(HDR_PH));
        chk("mid_rst_grant", 64'(Resp_Grant), 64'd1);
        chk("mid_rst_seq_err", 64'(Cpl_Seq_Err), 64'd0);
`ifdef P2A_CPL_STATS_EN
        chk("mid_rst_count", 64'(Cpl_Count), 64'd0);
`endif
        tick();
        ARESET = 1'b0;
        tick();
        push_beat(mk_hdr(1'b0, 10'd0, CPL_STATUS_SC), 7000);
        chk_data("post_rst_data", 7000);
        grant(1'b0);
        chk("post_rst_empty", 64'(Cpl_Valid), 64'd0);
        $display("reset mid-completion: buffer cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
